alu_share_arbiter: RTL and testbench

//  Shares the single execute-stage ALU between two requesters: port 0 (main execute path)
//  and port 1 (branch/address helper). Accepts one op (ALUControl code + two operands),

---
 rtl/alu_share_arbiter.sv | 153 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-port arbiter sharing one execute-stage ALU (optional ALU_ARB_RR_EN: round-robin grant)
module alu_share_arbiter #(
  parameter int WIDTH        = 32,
  parameter int CTRL_W       = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WIDTH-1:0]  rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp1_result,
  output logic              rsp1_zero,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [WIDTH-1:0]  a_q, b_q, res_q;
  logic              zero_q;
  logic              gnt0, gnt1, accept;

`ifdef ALU_ARB_RR_EN
  // last_grant starts at 1 so port 0 takes the first tie
  logic last_grant_q;

  // On a tie the port that did not win last time gets the ALU
  always_comb gnt1 = req1_valid && (!req0_valid || !last_grant_q);

  // Remember which port won the most recent accept
  always_ff @(posedge clk) begin
    if (rst)         last_grant_q <= 1'b1;
    else if (accept) last_grant_q <= gnt1;
  end
`else
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_cnt_q;

  // Port 0 has priority unless port 1 has been passed over LIMIT times in a row
  always_comb gnt1 = req1_valid && (!req0_valid || (starve_cnt_q == LIMIT));

  // Count port-0 wins while port 1 waits; any port-1 win clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else if (accept) begin
      if (gnt1)                                    starve_cnt_q <= '0;
      else if (req1_valid && starve_cnt_q != LIMIT) starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end
`endif

  assign gnt0   = req0_valid && !gnt1;
  assign accept = (state_q == IDLE) && (req0_valid || req1_valid);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latch the accepted op, then capture the ALU output during the single EXEC cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= 1'b0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      if (accept) begin
        owner_q <= gnt1;
        ctrl_q  <= gnt1 ? req1_ctrl : req0_ctrl;
        a_q     <= gnt1 ? req1_a    : req0_a;
        b_q     <= gnt1 ? req1_b    : req0_b;
      end
      if (state_q == EXEC) begin
        res_q  <= alu_result;
        zero_q <= alu_zero;
      end
    end
  end

  // Next state and all outputs; everything idles at zero
  always_comb begin
    state_d     = state_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    alu_ctrl    = '0;
    alu_a       = '0;
    alu_b       = '0;
    rsp0_valid  = 1'b0;
    rsp0_result = '0;
    rsp0_zero   = 1'b0;
    rsp1_valid  = 1'b0;
    rsp1_result = '0;
    rsp1_zero   = 1'b0;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        busy     = 1'b1;
        alu_ctrl = ctrl_q;
        alu_a    = a_q;
        alu_b    = b_q;
        state_d  = RESP;
      end
      RESP: begin
        busy = 1'b1;
        if (owner_q) begin
          rsp1_valid  = 1'b1;
          rsp1_result = res_q;
          rsp1_zero   = zero_q;
          if (rsp1_ready) state_d = IDLE;
        end else begin
          rsp0_valid  = 1'b1;
          rsp0_result = res_q;
          rsp0_zero   = zero_q;
          if (rsp0_ready) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter (honours ALU_ARB_RR_EN)
module tb_alu_share_arbiter;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [CTRL_W-1:0] req0_ctrl, req1_ctrl, alu_ctrl;
  logic [WIDTH-1:0]  req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result;
  logic              alu_zero;
  logic              rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [WIDTH-1:0]  rsp0_result, rsp1_result;
  logic              busy;

  int n_assert = 0;
  int n_fail   = 0;

  alu_share_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl), .req1_a(req1_a), .req1_b(req1_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared ALU: 0 add, 1 sub, 2 and, 3 or
  always_comb begin
    case (alu_ctrl)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a & alu_b;
      4'd3:    alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".busy"},      busy,        0);
    chk({tag, ".rsp0_v"},    rsp0_valid,  0);
    chk({tag, ".rsp1_v"},    rsp1_valid,  0);
    chk({tag, ".rsp0_res"},  rsp0_result, 0);
    chk({tag, ".rsp1_res"},  rsp1_result, 0);
    chk({tag, ".rsp0_z"},    rsp0_zero,   0);
    chk({tag, ".rsp1_z"},    rsp1_zero,   0);
    chk({tag, ".alu_ctrl"},  alu_ctrl,    0);
    chk({tag, ".alu_a"},     alu_a,       0);
    chk({tag, ".alu_b"},     alu_b,       0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[8];
    int n0, n1;
    rst = 1'b1;
    req0_valid = 0; req0_ctrl = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_ctrl = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    step(); step();
    #1;
    chk_quiet("reset");
    chk("reset.req0_ready", req0_ready, 0);
    chk("reset.req1_ready", req1_ready, 0);
    rst = 1'b0;
    step();

    // 1: lone req0 add 5+3
    req0_valid = 1; req0_ctrl = 4'd0; req0_a = 5; req0_b = 3;
    #1;
    chk("t1.req0_ready", req0_ready, 1);
    chk("t1.req1_ready", req1_ready, 0);
    chk("t1.busy_idle",  busy,       0);
    step();
    req0_valid = 0; req0_a = 0; req0_b = 0;
    #1;
    chk("t1.alu_a",     alu_a,      5);
    chk("t1.alu_b",     alu_b,      3);
    chk("t1.alu_ctrl",  alu_ctrl,   0);
    chk("t1.busy_exec", busy,       1);
    chk("t1.rsp0_v_ex", rsp0_valid, 0);
    step();
    #1;
    chk("t1.rsp0_v",    rsp0_valid,  1);
    chk("t1.rsp0_res",  rsp0_result, 8);
    chk("t1.rsp0_z",    rsp0_zero,   0);
    chk("t1.rsp1_v",    rsp1_valid,  0);
    chk("t1.alu_a_rsp", alu_a,       0);
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;
    #1;
    chk_quiet("t1.after");

    // 2: req1 sub 7-7 with a stalled consumer
    req1_valid = 1; req1_ctrl = 4'd1; req1_a = 7; req1_b = 7;
    #1;
    chk("t2.req1_ready", req1_ready, 1);
    step();
    req1_valid = 0;
    #1;
    chk("t2.alu_ctrl", alu_ctrl, 1);
    step();
    req0_valid = 1; req0_ctrl = 4'd3; req0_a = 1; req0_b = 2;
    rsp0_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2.rsp1_v[%0d]", i),   rsp1_valid,  1);
      chk($sformatf("t2.rsp1_res[%0d]", i), rsp1_result, 0);
      chk($sformatf("t2.rsp1_z[%0d]", i),   rsp1_zero,   1);
      chk($sformatf("t2.rsp0_v[%0d]", i),   rsp0_valid,  0);
      chk($sformatf("t2.req0_rdy[%0d]", i), req0_ready,  0);
      chk($sformatf("t2.req1_rdy[%0d]", i), req1_ready,  0);
      step();
    end
    req0_valid = 0; rsp0_ready = 0;
    rsp1_ready = 1;
    step();
    rsp1_ready = 0;
    #1;
    chk_quiet("t2.after");

    // 3/4: both ports requesting continuously
`ifdef ALU_ARB_RR_EN
    order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    order = '{0, 0, 0, 1, 0, 0, 0, 1};
`endif
    n0 = 0; n1 = 0;
    for (int g = 0; g < 8; g++) begin
      req0_valid = 1; req0_ctrl = 4'd0; req0_a = 32'(n0 + 1); req0_b = 1;
      req1_valid = 1; req1_ctrl = 4'd1; req1_a = 50;           req1_b = 32'(n1);
      #1;
      chk($sformatf("t3.req0_rdy[%0d]", g), req0_ready, (order[g] == 0));
      chk($sformatf("t3.req1_rdy[%0d]", g), req1_ready, (order[g] == 1));
      step();
      #1;
      chk($sformatf("t3.alu_a[%0d]", g), alu_a, (order[g] == 0) ? 32'(n0 + 1) : 32'd50);
      step();
      #1;
      chk($sformatf("t3.rsp0_v[%0d]", g), rsp0_valid, (order[g] == 0));
      chk($sformatf("t3.rsp1_v[%0d]", g), rsp1_valid, (order[g] == 1));
      if (order[g] == 0) begin
        chk($sformatf("t3.rsp0_res[%0d]", g), rsp0_result, 32'(n0 + 2));
        rsp0_ready = 1;
        n0++;
      end else begin
        chk($sformatf("t3.rsp1_res[%0d]", g), rsp1_result, 32'(50 - n1));
        rsp1_ready = 1;
        n1++;
      end
      step();
      rsp0_ready = 0; rsp1_ready = 0;
    end
    req0_valid = 0; req1_valid = 0;
    step();

    // 5: reset during EXEC drops the op
    req0_valid = 1; req0_ctrl = 4'd0; req0_a = 1; req0_b = 2;
    step();
    req0_valid = 0;
    #1;
    chk("t5.alu_a_exec", alu_a, 1);
    rst = 1;
    step();
    rst = 0;
    #1;
    chk_quiet("t5.rst");
    step();
    #1;
    chk_quiet("t5.norsp");
    req0_valid = 1; req0_ctrl = 4'd0; req0_a = 4; req0_b = 4;
    #1;
    chk("t5.req0_ready", req0_ready, 1);
    step();
    req0_valid = 0;
    step();
    #1;
    chk("t5.rsp0_v",   rsp0_valid,  1);
    chk("t5.rsp0_res", rsp0_result, 8);
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;

    // 6: req0 withdrawn just before it would be granted
    req0_valid = 1; req0_ctrl = 4'd0; req0_a = 2; req0_b = 2;
    step();
    req0_a = 9; req0_b = 9;
    req1_valid = 1; req1_ctrl = 4'd1; req1_a = 20; req1_b = 5;
    step();
    req0_valid = 0;
    rsp0_ready = 1;
    #1;
    chk("t6.rsp0_res_first", rsp0_result, 4);
    step();
    rsp0_ready = 0;
    #1;
    chk("t6.req0_ready", req0_ready, 0);
    chk("t6.req1_ready", req1_ready, 1);
    step();
    req1_valid = 0;
    #1;
    chk("t6.alu_a",    alu_a,    20);
    chk("t6.alu_ctrl", alu_ctrl, 1);
    step();
    #1;
    chk("t6.rsp1_v",   rsp1_valid,  1);
    chk("t6.rsp1_res", rsp1_result, 15);
    chk("t6.rsp0_v",   rsp0_valid,  0);
    rsp1_ready = 1;
    step();
    rsp1_ready = 0;
    #1;
    chk_quiet("t6.after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
